regfile_timer: RTL and testbench
================================

// Module: regfile_timer
// PURPOSE
//  Programmable interval timer/event counter driven by the AXI-BRAM register file.
//  - Consumes config words (reg_val) and one-cycle command strobes (pul_val) from the register file.
//  - Returns count/status words that are routed back onto read_val for CPU readback.
//  - Drives the board LEDs.
//  - Sits directly downstream of the register file, in the regfile_clk domain.
// PARAMETERS
//  Nbits  32  width of period, limit and count registers
//  Nled   8   LED output width
// PORTS
//  clk          in   1      regfile clock
//  rst_n        in   1      asynchronous active-low reset
//  cfg_ctrl     in   32     [0]=auto_reload, [1]=led_src (0: count LSBs, 1: state pattern), rest ignored
//  cfg_period   in   Nbits  prescaler terminal value P; one tick every P+1 cycles
//  cfg_limit    in   Nbits  tick count L that ends a run; 0 = free-running
//  pul_start    in   1      one-cycle strobe: (re)start a run
//  pul_stop     in   1      one-cycle strobe: halt run, hold count
//  pul_clear    in   1      one-cycle strobe: clear sticky flags and reload counter
//  stat_count   out  Nbits  current tick count
//  stat_word    out  32     [1:0]=state, [4]=done_sticky, [31:16]=reload_cnt, other bits 0
//  done_pulse   out  1      one-cycle pulse when a run reaches L
//  led          out  Nled   LED drive
// BEHAVIOUR
//  Reset (rst_n low, async):
//   - state=IDLE; all counters, shadows and flags = 0.
//   - Every output = 0.
//  States: IDLE=0, RUN=1, DONE=2 (3 unused; treated as IDLE if entered).
//  Config shadowing: cfg_ctrl, cfg_period and cfg_limit are latched on the cycle pul_start is accepted.
//   - Register writes during a run have no effect until the next start.
//  Start, pul_start high in cycle N (any state, stop low):
//   - count=0, presc=0, shadows loaded, state=RUN, all visible at N+1.
//   - pul_start while RUN restarts the run identically.
//  Prescaler (RUN only): presc counts 0..P, then wraps to 0.
//   - Tick occurs in the cycle presc==P.
//   - P=0 gives a tick every cycle.
//   - First tick after a start in cycle N occurs in cycle N+1+P; count=1 is visible at N+2+P.
//  On tick:
//   - If L!=0 and count+1==L:
//     - auto_reload=0: count=L, state=DONE, done_sticky=1, done_pulse=1 for one cycle.
//     - auto_reload=1: count=0, stay RUN, done_sticky=1, done_pulse=1, reload_cnt+=1.
//   - Otherwise count+=1, wrapping modulo 2^Nbits (free-running case).
//   - reload_cnt is 16 bits and saturates at 16'hFFFF.
//  Stop: pul_stop moves RUN->IDLE.
//   - count is held; presc is cleared.
//   - Stop is ignored in IDLE and DONE.
//  Simultaneous events:
//   - start+stop in the same cycle: stop wins; start is ignored.
//   - clear + terminal tick in the same cycle: done_sticky=1 and reload_cnt takes its post-tick value; the terminal event wins over clear.
//   - stop + terminal tick in the same cycle: stop wins; no done_pulse; count takes count+1 saturated to L.
//  Clear:
//   - Zeroes done_sticky and reload_cnt.
//   - Also zeroes count when state!=RUN.
//   - Does not change state.
//  DONE: count is held; only pul_start leaves DONE.
//  LEDs, registered:
//   - led_src=0: led = count[Nled-1:0].
//   - led_src=1: IDLE all 0, RUN alternating 8'h55/8'hAA per tick, DONE all 1.
//  Latency: all outputs are registered; each reflects the event of cycle N at cycle N+1.
// TESTING
//  1. Reset mid-run: P=3, L=0, start, then deassert rst_n for 1 cycle -> outputs 0, state IDLE immediately.
//  2. P=0, L=5, auto_reload=0:
//     - start at N -> stat_count 1..5 on N+2..N+6.
//     - done_pulse at N+6; stat_word=32'h0000_0012; count holds at 5.
//  3. P=2, L=4, auto_reload=1, run 36 cycles -> 3 reloads; reload_cnt=3; count cycles 0..3.
//  4. Change cfg_period/cfg_limit mid-run -> no effect until the next start; restart applies the new values.
//  5. Simultaneous events:
//     - start+stop in RUN -> IDLE with count held.
//     - clear on the terminal tick -> done_sticky=1.
//  6. Free-running wrap: P=0, L=0, Nbits=8 -> count 255 wraps to 0; state stays RUN; no done_pulse.

Source files
------------

// File: rtl/regfile_timer.sv
// Interval timer / event counter fed by the register file.
// In: cfg_ctrl/period/limit, start/stop/clear strobes. Out: stat_count, stat_word, done_pulse, led.
module regfile_timer #(
  parameter int Nbits = 32,
  parameter int Nled  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cfg_ctrl,
  input  logic [Nbits-1:0] cfg_period,
  input  logic [Nbits-1:0] cfg_limit,
  input  logic             pul_start,
  input  logic             pul_stop,
  input  logic             pul_clear,
  output logic [Nbits-1:0] stat_count,
  output logic [31:0]      stat_word,
  output logic             done_pulse,
  output logic [Nled-1:0]  led
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [Nled-1:0] alt55();
    logic [Nled-1:0] p;
    for (int i = 0; i < Nled; i++) p[i] = (i % 2 == 0);
    return p;
  endfunction

  localparam logic [Nled-1:0]  Pat55 = alt55();
  localparam logic [Nled-1:0]  PatAA = ~Pat55;
  localparam logic [Nbits-1:0] One   = 1;

  state_t           state_q, state_d;
  logic [Nbits-1:0] count_q, count_d;
  logic [Nbits-1:0] presc_q, presc_d;
  logic [Nbits-1:0] per_q, per_d;
  logic [Nbits-1:0] lim_q, lim_d;
  logic             auto_q, auto_d;
  logic             src_q, src_d;
  logic             sticky_q, sticky_d;
  logic [15:0]      rel_q, rel_d;
  logic             pulse_q, pulse_d;
  logic             phase_q, phase_d;
  logic [Nled-1:0]  led_q, led_d;

  logic             start_ok;
  logic             tick;
  logic             term;
  logic [Nbits-1:0] count_inc;
  logic [15:0]      rel_sat;
  logic             unused_ctrl;

  assign unused_ctrl = ^cfg_ctrl[31:2];

  // stop beats start when both strobe together
  assign start_ok  = pul_start & ~pul_stop;
  assign tick      = (state_q == RUN) && (presc_q == per_q);
  assign count_inc = count_q + One;
  assign term      = tick && (lim_q != '0)
                   && (count_inc == lim_q);
  assign rel_sat   = (rel_q == 16'hFFFF) ?
                     rel_q : rel_q + 16'd1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
    per_d    = per_q;
    lim_d    = lim_q;
    auto_d   = auto_q;
    src_d    = src_q;
    sticky_d = sticky_q;
    rel_d    = rel_q;
    pulse_d  = 1'b0;
    phase_d  = phase_q;

    if (pul_clear) begin
      sticky_d = 1'b0;
      rel_d    = '0;
      if (state_q != RUN) count_d = '0;
    end

    if (start_ok) begin
      state_d = RUN;
      count_d = '0;
      presc_d = '0;
      phase_d = 1'b0;
      per_d   = cfg_period;
      lim_d   = cfg_limit;
      auto_d  = cfg_ctrl[0];
      src_d   = cfg_ctrl[1];
    end else begin
      unique case (1'b1)
        (state_q == RUN): begin
          if (pul_stop) begin
            // a coinciding tick still lands; count < limit so
            // count+1 never overshoots it
            state_d = IDLE;
            presc_d = '0;
            if (tick) count_d = count_inc;
          end else if (tick) begin
            presc_d = '0;
            phase_d = ~phase_q;
            if (term) begin
              // terminal event overrides a same-cycle clear
              pulse_d  = 1'b1;
              sticky_d = 1'b1;
              rel_d    = rel_q;
              if (auto_q) begin
                count_d = '0;
                rel_d   = rel_sat;
              end else begin
                count_d = lim_q;
                state_d = DONE;
              end
            end else begin
              count_d = count_inc;
            end
          end else begin
            presc_d = presc_q + One;
          end
        end
        (state_q == DONE): begin
        end
        default: state_d = IDLE;
      endcase
    end

    led_d = count_d[Nled-1:0];
    if (src_d) begin
      unique case (1'b1)
        (state_d == RUN):  led_d = phase_d ? PatAA : Pat55;
        (state_d == DONE): led_d = '1;
        default:           led_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      presc_q  <= '0;
      per_q    <= '0;
      lim_q    <= '0;
      auto_q   <= 1'b0;
      src_q    <= 1'b0;
      sticky_q <= 1'b0;
      rel_q    <= '0;
      pulse_q  <= 1'b0;
      phase_q  <= 1'b0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
      per_q    <= per_d;
      lim_q    <= lim_d;
      auto_q   <= auto_d;
      src_q    <= src_d;
      sticky_q <= sticky_d;
      rel_q    <= rel_d;
      pulse_q  <= pulse_d;
      phase_q  <= phase_d;
      led_q    <= led_d;
    end
  end

  assign stat_count = count_q;
  assign stat_word  = {rel_q, 11'd0, sticky_q,
                       2'd0, state_q};
  assign done_pulse = pulse_q;
  assign led        = led_q;

endmodule

// File: tb/tb_regfile_timer.sv
// Self-checking bench for regfile_timer (Nbits=8).
// Table vectors, directed corner sequences, random run vs. a tick-count model.
module tb_regfile_timer;

  localparam int NB = 8;
  localparam int NL = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [31:0]   cfg_ctrl = '0;
  logic [NB-1:0] cfg_period = '0;
  logic [NB-1:0] cfg_limit = '0;
  logic          pul_start = 1'b0;
  logic          pul_stop = 1'b0;
  logic          pul_clear = 1'b0;
  logic [NB-1:0] stat_count;
  logic [31:0]   stat_word;
  logic          done_pulse;
  logic [NL-1:0] led;

  always #5 clk = ~clk;

  regfile_timer #(.Nbits(NB), .Nled(NL)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_ctrl(cfg_ctrl), .cfg_period(cfg_period),
    .cfg_limit(cfg_limit), .pul_start(pul_start),
    .pul_stop(pul_stop), .pul_clear(pul_clear),
    .stat_count(stat_count), .stat_word(stat_word),
    .done_pulse(done_pulse), .led(led)
  );

  int n_vec = 0;
  int n_bad = 0;
  int npul  = 0;

  // model: run progress kept as cycles-in-run and ticks-in-run
  int m_state, m_age, m_ticks, m_held;
  int m_P, m_L, m_ar, m_src, m_sticky, m_rel, m_pulse;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic int m_count();
    if (m_state == 1)
      return (m_L == 0) ? m_ticks % 256 : m_ticks % m_L;
    return m_held;
  endfunction

  function automatic int m_led();
    if (m_src == 0) return m_count();
    if (m_state == 1) return (m_ticks % 2) ? 'hAA : 'h55;
    if (m_state == 2) return 'hFF;
    return 0;
  endfunction

  function automatic logic [31:0] m_word();
    logic [31:0] w;
    w = '0;
    w[31:16] = m_rel[15:0];
    w[4]     = m_sticky[0];
    w[1:0]   = m_state[1:0];
    return w;
  endfunction

  task automatic m_reset();
    m_state = 0; m_age = 0; m_ticks = 0; m_held = 0;
    m_P = 0; m_L = 0; m_ar = 0; m_src = 0;
    m_sticky = 0; m_rel = 0; m_pulse = 0;
  endtask

  task automatic model_step();
    int tick, nt, term, old_rel;
    old_rel = m_rel;
    m_pulse = 0;
    tick = (m_state == 1) && (m_age % (m_P + 1) == m_P);
    if (pul_start && !pul_stop) begin
      if (pul_clear) begin m_sticky = 0; m_rel = 0; end
      m_state = 1; m_age = 0; m_ticks = 0;
      m_P = cfg_period; m_L = cfg_limit;
      m_ar = cfg_ctrl[0]; m_src = cfg_ctrl[1];
    end else if (m_state == 1) begin
      nt = m_ticks + tick;
      if (pul_stop) begin
        m_held = (m_count() + tick) % 256;
        m_state = 0;
        if (pul_clear) begin m_sticky = 0; m_rel = 0; end
      end else begin
        term = tick && (m_L != 0) && (nt % m_L == 0);
        if (pul_clear) begin m_sticky = 0; m_rel = 0; end
        if (term) begin
          m_pulse = 1;
          m_sticky = 1;
          m_rel = m_ar ? ((old_rel < 65535) ? old_rel + 1 : old_rel)
                       : old_rel;
          if (!m_ar) begin m_state = 2; m_held = m_L; end
        end
        m_ticks = nt;
        m_age++;
      end
    end else if (pul_clear) begin
      m_sticky = 0; m_rel = 0; m_held = 0;
    end
  endtask

  task automatic idle_in();
    pul_start = 1'b0; pul_stop = 1'b0; pul_clear = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    chk("count", 32'(stat_count), 32'(m_count()));
    chk("word", stat_word, m_word());
    chk("pulse", 32'(done_pulse), 32'(m_pulse));
    chk("led", 32'(led), 32'(m_led()));
    npul += int'(done_pulse);
    idle_in();
  endtask

  task automatic go(input logic [31:0] c,
                    input int p, input int l,
                    input logic clr);
    cfg_ctrl = c; cfg_period = NB'(p); cfg_limit = NB'(l);
    pul_start = 1'b1; pul_clear = clr;
    step();
  endtask

  typedef struct {
    logic st, sp, cl;
    logic [31:0] ctrl;
    logic [7:0]  per, lim;
    logic [7:0]  e_cnt;
    logic [31:0] e_word;
    logic        e_pul;
    logic [7:0]  e_led;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1,0,0, 0, 0, 5, 0, 32'h01, 0, 0};
    tbl[1] = '{0,0,0, 0, 0, 5, 1, 32'h01, 0, 1};
    tbl[2] = '{0,0,0, 0, 0, 5, 2, 32'h01, 0, 2};
    tbl[3] = '{0,0,0, 0, 0, 5, 3, 32'h01, 0, 3};
    tbl[4] = '{0,0,0, 0, 0, 5, 4, 32'h01, 0, 4};
    tbl[5] = '{0,0,0, 0, 0, 5, 5, 32'h12, 1, 5};
    tbl[6] = '{0,0,0, 0, 0, 5, 5, 32'h12, 0, 5};
    tbl[7] = '{0,0,1, 0, 0, 5, 0, 32'h02, 0, 0};
    tbl[8] = '{0,1,0, 0, 0, 5, 0, 32'h02, 0, 0};

    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(stat_count), 0);
    chk("rst_word", stat_word, 0);
    chk("rst_pulse", 32'(done_pulse), 0);
    chk("rst_led", 32'(led), 0);
    rst_n = 1'b1;

    // reset in the middle of a run
    go(32'h2, 3, 0, 0);
    repeat (6) step();
    rst_n = 1'b0;
    #2;
    chk("arst_count", 32'(stat_count), 0);
    chk("arst_word", stat_word, 0);
    chk("arst_led", 32'(led), 0);
    chk("arst_pulse", 32'(done_pulse), 0);
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // one-shot run, L=5
    for (int i = 0; i < 9; i++) begin
      pul_start = tbl[i].st; pul_stop = tbl[i].sp;
      pul_clear = tbl[i].cl; cfg_ctrl = tbl[i].ctrl;
      cfg_period = tbl[i].per; cfg_limit = tbl[i].lim;
      step();
      chk($sformatf("tbl%0d_count", i),
          32'(stat_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_word", i),
          stat_word, tbl[i].e_word);
      chk($sformatf("tbl%0d_pulse", i),
          32'(done_pulse), 32'(tbl[i].e_pul));
      chk($sformatf("tbl%0d_led", i),
          32'(led), 32'(tbl[i].e_led));
    end

    // config writes mid-run are shadowed
    go(32'h0, 1, 5, 0);
    cfg_period = 0; cfg_limit = 2;
    repeat (4) step();
    chk("shadow_count", 32'(stat_count), 2);
    chk("shadow_state", 32'(stat_word[1:0]), 1);
    go(32'h0, 0, 2, 0);
    repeat (2) step();
    chk("newcfg_count", 32'(stat_count), 2);
    chk("newcfg_state", 32'(stat_word[1:0]), 2);

    // auto-reload, P=2 L=4, 36 cycles
    go(32'h1, 2, 4, 1);
    npul = 0;
    repeat (36) step();
    chk("ar_reloads", 32'(stat_word[31:16]), 3);
    chk("ar_count", 32'(stat_count), 0);
    chk("ar_pulses", 32'(npul), 3);

    // start+stop in RUN: stop wins, count held
    go(32'h0, 3, 0, 0);
    repeat (5) step();
    pul_start = 1'b1; pul_stop = 1'b1;
    step();
    chk("ss_count", 32'(stat_count), 1);
    chk("ss_state", 32'(stat_word[1:0]), 0);

    // clear on the terminal tick
    pul_clear = 1'b1;
    step();
    go(32'h1, 0, 3, 0);
    repeat (2) step();
    pul_clear = 1'b1;
    step();
    chk("clrterm_word", stat_word, 32'h0001_0011);
    chk("clrterm_pulse", 32'(done_pulse), 1);

    // free-running wrap
    go(32'h0, 0, 0, 0);
    npul = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i == 254)
        chk("wrap_pre", 32'(stat_count), 255);
    end
    chk("wrap_count", 32'(stat_count), 0);
    chk("wrap_state", 32'(stat_word[1:0]), 1);
    chk("wrap_nopulse", 32'(npul), 0);

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      pul_start = ($urandom_range(0, 99) < 4);
      pul_stop  = ($urandom_range(0, 99) < 3);
      pul_clear = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 9) == 0) begin
        cfg_ctrl   = $urandom;
        cfg_period = NB'($urandom_range(0, 3));
        cfg_limit  = NB'($urandom_range(0, 6));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
